data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
Responder end of the core's data-memory interface. It accepts one load/store request at a time over a valid/ready request channel and performs sized accesses selected by DQM. Accesses go to an internal word-organised storage array. After a programmable number of wait states it returns read data, or a completion for stores, over a valid/ready response channel. It replaces the zero-latency combinational data memory once the core gains stall support.

Parameters:
DEPTH, 1024, number of 32-bit words in storage (power of two)
WAIT_CYCLES, 1, extra cycles between request acceptance and response valid (0..15)
INIT_ZERO, 1, 1 = storage cleared to zero by reset; 0 = storage not reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
req_dqm  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_rdata  output  32  load data, right-justified, zero-filled above size; 0 for stores and errors
rsp_err  output  1  misaligned, out-of-range or reserved-DQM access

Behaviour:
- Reset (rst low, asynchronous): state IDLE; req_ready=0 while rst is low; rsp_valid=0, rsp_rdata=0, rsp_err=0. If INIT_ZERO=1, all words are cleared.
- req_ready is 1 only in IDLE with rst high.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: handshake is req_valid&req_ready at edge T. The responder captures we, addr, wdata and dqm at T.
  - IDLE transition: to WAIT if WAIT_CYCLES>0, otherwise to RESP.
  - WAIT: down-counter loaded with WAIT_CYCLES-1; go to RESP when it reaches 0.
- Response timing: rsp_valid rises at T+1+WAIT_CYCLES. rsp_rdata and rsp_err are registered and stay stable while rsp_valid=1 and rsp_ready=0.
- RESP: on rsp_valid&rsp_ready the FSM returns to IDLE. req_ready is 1 on the next cycle, so back-to-back throughput is one request per 2+WAIT_CYCLES cycles.
- Word index is req_addr[log2(DEPTH)+1:2]; lane is req_addr[1:0].
- Error conditions, any one sets rsp_err=1:
  - dqm=01 with addr[0]=1
  - dqm=10 with addr[1:0]!=0
  - dqm=11
  - req_addr[31:log2(DEPTH)+2] nonzero
- On error: no storage write, and rsp_rdata=0.
- Store commit: at the edge where rsp_valid rises, not at acceptance. Only the addressed byte lanes change.
  - byte: lane=addr[1:0] gets wdata[7:0]
  - half: lanes addr[1]*2+{0,1} get wdata[15:0]
  - word: all four lanes
- Load: rsp_rdata is the addressed byte or half shifted down to bit 0, upper bits 0; word loads return the whole word. Sign extension is the load unit's job, not this block's.
- A load that follows a store to the same word sees the stored value, because the store commits before the load is accepted.
- Reset mid-operation:
  - An in-flight request is dropped.
  - A store whose response had not yet been raised does not modify storage.
  - When INIT_ZERO=0, storage contents survive reset.
- Inputs are ignored outside the IDLE handshake. Holding req_valid high during WAIT or RESP has no effect.

Decomposition:
- Shared package holds:
  - DQM size encodings: DQM_BYTE=2'b00, DQM_HALF=2'b01, DQM_WORD=2'b10
  - FSM state encoding: IDLE, WAIT, RESP
  - MAX_WAIT=15
- One sub-module, mem_lane_align. It is combinational and computes:
  - byte-enable mask, write-data lane placement and read-data extraction from dqm and addr[1:0]
  - the misalignment flag
- The FSM, counter and storage array stay in data_mem_responder.

Test Plan:
- Setup: WAIT_CYCLES=2, rsp_ready=1.
- Word store then load: store addr=0x10 wdata=0xDEADBEEF dqm=10, then load addr=0x10 dqm=10. Expect rsp_valid 3 cycles after each acceptance, load rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte lanes: after the word above, store byte 0x5A at addr=0x13. Word load at 0x10 -> 0x5AADBEEF; byte load at 0x12 -> 0x000000AD; half load at 0x10 -> 0x0000BEEF.
- Misaligned/reserved: half load addr=0x11, word store addr=0x12, and dqm=11. Each gives rsp_err=1 and rsp_rdata=0; a following word load at 0x10 is unchanged at 0x5AADBEEF.
- Out of range: DEPTH=1024, load addr=0x00001000 -> rsp_err=1; store addr=0x00001000 leaves word 0 unmodified.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load. rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0; after rsp_ready=1 for one cycle, req_ready=1 next cycle.
- Reset mid-op: accept store 0x11111111 at 0x20, drop rst during WAIT. Outputs are 0 immediately; after release, load 0x20 returns the prior value (0 with INIT_ZERO=1).

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the wait-state ceiling.
package data_mem_responder_pkg;

  localparam logic [1:0] DQM_BYTE = 2'b00;
  localparam logic [1:0] DQM_HALF = 2'b01;
  localparam logic [1:0] DQM_WORD = 2'b10;

  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } stateT;

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// Combinational lane steering between a 32-bit storage word and right-justified
// request/response data, plus detection of misaligned or reserved-size accesses.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  dqm,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byteEn,
  output logic [31:0] wdataLane,
  output logic [31:0] rdataLane,
  output logic        misaligned
);

  logic [31:0] shifted;

  // Replicating the store data across lanes lets byteEn alone pick which bytes land.
  always_comb begin
    byteEn     = 4'b0000;
    wdataLane  = wdata;
    rdataLane  = 32'h0;
    misaligned = 1'b0;
    shifted    = rword >> {lane, 3'b000};
    case (dqm)
      DQM_BYTE: begin
        byteEn    = 4'b0001 << lane;
        wdataLane = {4{wdata[7:0]}};
        rdataLane = {24'h0, shifted[7:0]};
      end
      DQM_HALF: begin
        byteEn     = lane[1] ? 4'b1100 : 4'b0011;
        wdataLane  = {2{wdata[15:0]}};
        rdataLane  = {16'h0, shifted[15:0]};
        misaligned = lane[0];
      end
      DQM_WORD: begin
        byteEn     = 4'b1111;
        wdataLane  = wdata;
        rdataLane  = rword;
        misaligned = (lane != 2'b00);
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time over valid/ready, a fixed number
// of wait states, then a registered response; stores commit as the response rises.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int INIT_ZERO   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_dqm,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDXW = $clog2(DEPTH);

  stateT state, stateNext;
  logic [3:0]  waitCnt;
  logic        capWe;
  logic [31:0] capAddr, capWdata;
  logic [1:0]  capDqm;
  logic        selWe;
  logic [31:0] selAddr, selWdata;
  logic [1:0]  selDqm;
  logic        accept, enterResp, rangeErr, misaligned, reqErr, memWrite;
  logic [IDXW-1:0] wordIdx;
  logic [3:0]  byteEn;
  logic [31:0] wdataLane, rdataLane, rspRdataQ;
  logic        rspErrQ;
  logic [31:0] mem [DEPTH];

  assign req_ready = (state == IDLE) && rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rspRdataQ;
  assign rsp_err   = rspErrQ;

  // With zero wait states the response is built on the acceptance edge, so the
  // live request must be used before it has been captured.
  always_comb begin
    selWe    = capWe;
    selAddr  = capAddr;
    selWdata = capWdata;
    selDqm   = capDqm;
    if (state == IDLE) begin
      selWe    = req_we;
      selAddr  = req_addr;
      selWdata = req_wdata;
      selDqm   = req_dqm;
    end
  end

  assign enterResp = ((state == WAIT) && (waitCnt == 4'd0)) || (accept && (WAIT_CYCLES == 0));
  assign rangeErr  = (selAddr >> (IDXW + 2)) != 32'h0;
  assign reqErr    = misaligned || rangeErr;
  assign memWrite  = enterResp && selWe && !reqErr;
  assign wordIdx   = selAddr[IDXW+1:2];

  mem_lane_align uAlign (
    .dqm       (selDqm),
    .lane      (selAddr[1:0]),
    .wdata     (selWdata),
    .rword     (mem[wordIdx]),
    .byteEn    (byteEn),
    .wdataLane (wdataLane),
    .rdataLane (rdataLane),
    .misaligned(misaligned)
  );

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (waitCnt == 4'd0) stateNext = RESP;
      RESP:    if (rsp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      waitCnt  <= 4'd0;
      capWe    <= 1'b0;
      capAddr  <= 32'h0;
      capWdata <= 32'h0;
      capDqm   <= DQM_BYTE;
    end else begin
      state <= stateNext;
      if (accept) begin
        capWe    <= req_we;
        capAddr  <= req_addr;
        capWdata <= req_wdata;
        capDqm   <= req_dqm;
        waitCnt  <= 4'(WAIT_CYCLES - 1);
      end else if ((state == WAIT) && (waitCnt != 4'd0)) begin
        waitCnt <= waitCnt - 4'd1;
      end
    end
  end

  // Response data is cleared once taken so an idle responder presents zeros.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rspRdataQ <= 32'h0;
      rspErrQ   <= 1'b0;
    end else if (enterResp) begin
      rspErrQ   <= reqErr;
      rspRdataQ <= (selWe || reqErr) ? 32'h0 : rdataLane;
    end else if ((state == RESP) && rsp_ready) begin
      rspRdataQ <= 32'h0;
      rspErrQ   <= 1'b0;
    end
  end

  if (INIT_ZERO != 0) begin : gInitZero
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      end else if (memWrite) begin
        for (int b = 0; b < 4; b++)
          if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wdataLane[8*b +: 8];
      end
    end
  end else begin : gNoInit
    always_ff @(posedge clk) begin
      if (memWrite) begin
        for (int b = 0; b < 4; b++)
          if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wdataLane[8*b +: 8];
      end
    end
  end

endmodule
